// File: rtl/router_pkg.sv
// Shared NoC definitions: control-bit positions, PE transmit FSM states and packet packing.
package router_pkg;

  localparam int CTRL_VALID_BIT = 0;
  localparam int CTRL_TAIL_BIT  = 1;
  // Packing is done at this fixed width; callers cast the result to their packet width.
  localparam int PKT_MAX        = 128;

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    WAIT_LO
  } tx_state_t;

  function automatic logic [PKT_MAX-1:0] pack_packet(
    input logic [PKT_MAX-1:0] dst_x,
    input logic [PKT_MAX-1:0] dst_y,
    input logic               last,
    input logic [PKT_MAX-1:0] payload,
    input int                 y_bits,
    input int                 payload_bits
  );
    logic [PKT_MAX-1:0] ctrl;
    ctrl                 = '0;
    ctrl[CTRL_TAIL_BIT]  = last;
    ctrl[CTRL_VALID_BIT] = 1'b1;
    return (dst_x << (y_bits + 2 + payload_bits)) |
           (dst_y << (2 + payload_bits)) |
           (ctrl << payload_bits) |
           payload;
  endfunction

endpackage

// File: rtl/noc_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module noc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/noc_pe_tx.sv
// PE-side NoC injector: FIFO-buffered local stream to a four-phase req/ack router port.
// Define NOC_PE_TX_STATS_EN to add the pkt_sent / stall_cycles counters.
module noc_pe_tx
  import router_pkg::*;
#(
  parameter int PAYLOAD     = 32,
  parameter int X_BITS      = 1,
  parameter int Y_BITS      = 1,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int PACKET_SIZE = X_BITS + Y_BITS + 2 + PAYLOAD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [X_BITS-1:0]             in_dst_x,
  input  logic [Y_BITS-1:0]             in_dst_y,
  input  logic                          in_last,
  input  logic [PAYLOAD-1:0]            in_payload,
  output logic                          net_req,
  output logic [PACKET_SIZE-1:0]        net_data,
  input  logic                          net_ack,
  output logic                          drop_self,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef NOC_PE_TX_STATS_EN
  ,
  output logic [31:0]                   pkt_sent,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PACKET_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_rd_ptr;
  logic [PACKET_SIZE-1:0] r_net_data;
  logic                   r_net_req;
  logic                   r_drop;
  tx_state_t              r_state;
  tx_state_t              w_state_next;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_self;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_load;
  logic                   w_req_next;
  logic                   w_ack_s;
  logic [PACKET_SIZE-1:0] w_in_pkt;

  assign w_self   = (in_dst_x == X_BITS'(SRC_X)) && (in_dst_y == Y_BITS'(SRC_Y));
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready && !w_self;

  assign w_in_pkt = PACKET_SIZE'(pack_packet(PKT_MAX'(in_dst_x), PKT_MAX'(in_dst_y), in_last,
                                             PKT_MAX'(in_payload), Y_BITS, PAYLOAD));

  noc_sync2 u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (net_ack),
    .o_q (w_ack_s)
  );

  // Storage carries no reset; clearing the pointers is what discards the contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_in_pkt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_drop <= in_valid && w_self;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_net_req  <= 1'b0;
      r_net_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_net_req <= w_req_next;
      if (w_load) r_net_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // An ack seen in IDLE is a protocol error and deliberately has no effect.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_net_req;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load       = 1'b1;
          w_req_next   = 1'b1;
          w_state_next = REQ_HI;
        end
      end
      REQ_HI: begin
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_pop        = 1'b1;
          w_state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!w_ack_s) begin
          if (!w_empty) begin
            w_load       = 1'b1;
            w_req_next   = 1'b1;
            w_state_next = REQ_HI;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign net_req    = r_net_req;
  assign net_data   = r_net_data;
  assign drop_self  = r_drop;
  assign busy       = !w_empty || (r_state != IDLE);
  assign fifo_count = r_wr_ptr - r_rd_ptr;

`ifdef NOC_PE_TX_STATS_EN
  logic [31:0] r_pkt_sent;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_sent     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_state == REQ_HI && w_state_next == WAIT_LO) r_pkt_sent <= r_pkt_sent + 1'b1;
      if (in_valid && !in_ready) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign pkt_sent     = r_pkt_sent;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/noc_pe_tx.md
Name: noc_pe_tx

Overview:
- Clocked processing-element-side injector for the 2x2 corner-router NoC.
- Accepts payload words on a local valid/ready stream and buffers them in a small FIFO.
- Builds NoC packets and drives the router's processor input port (req/data, with ack returned) using a four-phase return-to-zero handshake.
- One instance sits next to each router node; the NoC's req_i/data_i/ack_i for node (SRC_X,SRC_Y) connect to net_req/net_data/net_ack.

Parameters:
- PAYLOAD, 32, payload width in bits.
- X_BITS, 1, destination X field width.
- Y_BITS, 1, destination Y field width.
- SRC_X, 0, X coordinate of the attached node.
- SRC_Y, 0, Y coordinate of the attached node.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.
- PACKET_SIZE, X_BITS+Y_BITS+2+PAYLOAD, NoC packet width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  local word valid.
- in_ready  out  1  FIFO can accept a word.
- in_dst_x  in  X_BITS  destination X.
- in_dst_y  in  Y_BITS  destination Y.
- in_last  in  1  tail-of-message flag.
- in_payload  in  PAYLOAD  payload.
- net_req  out  1  request to router processor input.
- net_data  out  PACKET_SIZE  packet to router.
- net_ack  in  1  acknowledge from router; asynchronous to clk.
- drop_self  out  1  one-cycle pulse when a self-addressed word is discarded.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Packet layout, MSB to LSB: {dst_x, dst_y, ctrl[1:0], payload}.
  - ctrl[1] = in_last.
  - ctrl[0] = 1 (valid marker).
- Reset values: net_req=0, net_data=0, in_ready=0 while rst is high then 1, drop_self=0, busy=0, fifo_count=0. FSM goes to IDLE and the FIFO pointers clear.
- Input accept:
  - A word is accepted on a clk edge where in_valid && in_ready.
  - in_ready = !full. There is no same-cycle pass-through when full, even if a pop happens that cycle.
- Self-addressed words (dst == {SRC_X,SRC_Y}):
  - Accepted but not written to the FIFO.
  - drop_self is high for the following cycle.
  - Accepted even when the FIFO is full.
- net_ack passes through a 2-flop synchronizer before use; the synchronized value is ack_s.
- FSM IDLE:
  - If the FIFO is non-empty, load the head packet into the net_data register, set net_req=1, go to REQ_HI.
  - Earliest net_req is one edge after the accept edge.
- FSM REQ_HI:
  - Hold net_req and net_data.
  - When ack_s=1, clear net_req, pop the FIFO, go to WAIT_LO.
- FSM WAIT_LO:
  - net_data is held.
  - When ack_s=0: if the FIFO is non-empty (after the pop), load the next packet, set net_req=1 and go to REQ_HI; otherwise go to IDLE.
- net_data is stable from net_req rise until ack_s=0 is observed. It changes only on load.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- FIFO pointers carry one extra bit. Wrap is modulo FIFO_DEPTH. full = MSBs differ with the rest equal.
- Reset mid-handshake:
  - net_req drops immediately (asynchronously).
  - The FIFO contents are lost.
  - rst is shared with the NoC, so router state clears too.
- net_ack rising while in IDLE is a protocol error: it is ignored and the state does not change.

Optional Feature:
- Macro NOC_PE_TX_STATS_EN.
- When defined, adds outputs:
  - pkt_sent[31:0]: increments on each REQ_HI->WAIT_LO transition.
  - stall_cycles[31:0]: increments each cycle in_valid && !in_ready.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, these ports and their logic are absent.

Decomposition:
- router_pkg gains:
  - CTRL_VALID_BIT=0 and CTRL_TAIL_BIT=1 constants.
  - A tx_state_t enum {IDLE, REQ_HI, WAIT_LO}.
  - A pack_packet() function taking dst_x, dst_y, last and payload.
- One sub-module, noc_sync2: 2-flop synchronizer with async active-high reset to 0. It is reused by a future receive-side block.

Test Plan:
- Single word: dst=(1,0) (SRC=(0,0)), last=1, payload=0xDEADBEEF -> net_data={1,0,2'b11,0xDEADBEEF}, net_req rises one edge after accept. Bench acks after 3 cycles, net_req falls 2–3 cycles later, bench drops ack -> IDLE, busy=0.
- Back-to-back: 4 words, bench never acks -> in_ready=0 after the 4th, fifo_count=4, net_data holds word 0. Then ack/unack cycles deliver all 4 in order.
- Self-address: dst=(0,0) at SRC=(0,0) -> drop_self pulses one cycle, net_req stays 0, fifo_count stays 0.
- Full with simultaneous pop: FIFO full, ack_s rises in REQ_HI -> in_ready=1 the next cycle, a push that cycle leaves count at 4.
- Reset in REQ_HI: assert rst asynchronously -> net_req=0 immediately, fifo_count=0. After release, a new word is transmitted normally.
- Stats build (NOC_PE_TX_STATS_EN): 3 packets sent and 5 stall cycles -> pkt_sent=3, stall_cycles=5.
